// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared memory-bus definitions (state encodings, error read data)
package mem_arbiter_pkg;

  // Arbiter states: IDLE arbitrates, BUSY forwards the granted master to the slave bus.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Read data returned to a master whose access was forced complete by the timeout.
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Default number of slave-wait cycles allowed per transaction.
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/bus_timeout.sv
// rtl/bus_timeout.sv - saturating slave-wait counter with expiry flag
module bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = (count == LAST);

  // Count wait cycles; hold at the expiry value so the counter never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter for the shared slave bus with timeout
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        owner,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  arb_state_t state, state_nxt;
  logic       rr;          // index of the master served last; reset value 1 favours m0
  logic       grant_idx;
  logic       gm_valid;
  logic       expired;
  logic       done;
  logic       timeout_hit;
  logic       busy;

  assign busy        = (state == ST_BUSY);
  assign gm_valid    = owner ? m1_valid : m0_valid;
  assign done        = busy && gm_valid && (s_ready || expired);
  assign timeout_hit = busy && gm_valid && !s_ready && expired;

  // Counter sits at zero while idle so every BUSY entry starts from a cleared count.
  bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!busy),
    .enable  (busy && gm_valid && !s_ready),
    .expired (expired)
  );

  // State, grant, round-robin pointer and timeout error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      rr       <= 1'b1;
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else begin
      state   <= state_nxt;
      bus_err <= timeout_hit;
      if (state == ST_IDLE && (m0_valid || m1_valid)) begin
        owner <= grant_idx;
      end
      if (done) begin
        rr <= owner;
      end
      if (timeout_hit) begin
        err_addr <= s_addr;
      end
    end
  end

  // Next-state selection and combinational routing between masters and the slave bus.
  always_comb begin
    state_nxt = state;
    grant_idx = (m0_valid && m1_valid) ? ~rr : m1_valid;
    s_valid   = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    case (state)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        s_valid = gm_valid;
        s_addr  = owner ? m1_addr  : m0_addr;
        s_wdata = owner ? m1_wdata : m0_wdata;
        s_wstrb = owner ? m1_wstrb : m0_wstrb;
        if (owner) begin
          m1_ready = done;
          m1_rdata = timeout_hit ? ERR_RDATA : s_rdata;
        end else begin
          m0_ready = done;
          m0_rdata = timeout_hit ? ERR_RDATA : s_rdata;
        end
        if (!gm_valid || done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
